fish_game_ctrl: RTL and testbench

FISH_GAME_CTRL -- requirements
Module: fish_game_ctrl

---
 rtl/fish_game_pkg.sv | 42 ++++
 rtl/fish_game_if.sv | 32 +++
 rtl/fish_mover.sv | 53 +++++
 rtl/fish_game_ctrl.sv | 148 ++++++++++++++
 tb/tb_fish_game_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fish_game_pkg.sv
// Fish game shared types and helpers.
// Holds state encodings, level geometry and parameter defaults.
package fish_game_pkg;

  localparam int NUM_LEVELS_D = 3;
  localparam int X_W_D        = 10;
  localparam int Y_W_D        = 10;
  localparam int SCREEN_W_D   = 640;
  localparam int FISH_TICKS_D = 500;
  localparam int REEL_STEP_D  = 2;
  localparam int WATER_Y_D    = 155;
  localparam int MAX_LIVES_D  = 3;

  // One-hot so the flags come straight off the state register.
  typedef enum logic [3:0] {
    ST_I     = 4'b0001,
    ST_FISH  = 4'b0010,
    ST_CATCH = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  // Fish length for level k: 20 - 5k.
  function automatic logic [4:0] fish_len(input logic [1:0] k);
    case (k)
      2'd0:    return 5'd20;
      2'd1:    return 5'd15;
      2'd2:    return 5'd10;
      default: return 5'd5;
    endcase
  endfunction

  // Fish row for level k: 390 - 90k.
  function automatic logic [9:0] fish_y(input logic [1:0] k);
    case (k)
      2'd0:    return 10'd390;
      2'd1:    return 10'd300;
      2'd2:    return 10'd210;
      default: return 10'd120;
    endcase
  endfunction

endpackage

// File: rtl/fish_game_if.sv
// Fish game control/status bundle.
// The player side drives buttons and rod; the controller reports game state.
interface fish_game_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           Start;
  logic           Ack;
  logic           BtnU;
  logic [X_W-1:0] rpos;
  logic [X_W-1:0] fpos;
  logic [Y_W-1:0] ypos;
  logic [1:0]     level;
  logic [2:0]     lives;
  logic [7:0]     score;
  logic           q_I;
  logic           q_Fish;
  logic           q_Catch;
  logic           q_Done;

  modport master (
    output Start, Ack, BtnU, rpos,
    input  fpos, ypos, level, lives, score,
    input  q_I, q_Fish, q_Catch, q_Done
  );

  modport slave (
    input  Start, Ack, BtnU, rpos,
    output fpos, ypos, level, lives, score,
    output q_I, q_Fish, q_Catch, q_Done
  );
endinterface

// File: rtl/fish_mover.sv
// Fish horizontal motion: step timer plus wrapping position.
// Even levels swim right, odd levels swim left.
module fish_mover #(
  parameter int X_W        = 10,
  parameter int SCREEN_W   = 640,
  parameter int FISH_TICKS = 500
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           clr_pos,
  input  logic           clr_tmr,
  input  logic           en,
  input  logic           dir_left,
  output logic [X_W-1:0] fpos
);

  localparam int TW = $clog2(FISH_TICKS + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(FISH_TICKS - 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);

  logic [TW-1:0]  timer;
  logic [X_W-1:0] fpos_step;
  logic           step;

  assign step = en && (timer == T_LAST);

  // One-pixel move with wrap at either screen edge.
  always_comb begin
    fpos_step = fpos;
    if (dir_left)
      fpos_step = (fpos == '0) ? X_LAST : fpos - 1'b1;
    else
      fpos_step = (fpos == X_LAST) ? '0 : fpos + 1'b1;
  end

  // Tick timer and position; clears win over stepping.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      timer <= '0;
      fpos  <= '0;
    end else begin
      if (clr_tmr)
        timer <= '0;
      else if (en)
        timer <= (timer == T_LAST) ? '0 : timer + 1'b1;
      if (clr_pos)
        fpos <= '0;
      else if (step)
        fpos <= fpos_step;
    end
  end

endmodule

// File: rtl/fish_game_ctrl.sv
// Fish game controller: idle, fishing, reeling, done.
// Tracks level, hook height, lives and a saturating score.
module fish_game_ctrl
  import fish_game_pkg::*;
#(
  parameter int NUM_LEVELS = NUM_LEVELS_D,
  parameter int X_W        = X_W_D,
  parameter int Y_W        = Y_W_D,
  parameter int SCREEN_W   = SCREEN_W_D,
  parameter int FISH_TICKS = FISH_TICKS_D,
  parameter int REEL_STEP  = REEL_STEP_D,
  parameter int WATER_Y    = WATER_Y_D,
  parameter int MAX_LIVES  = MAX_LIVES_D
) (
  input logic       Clk,
  input logic       Reset,
  fish_game_if.slave bus
);

  localparam int XW1 = X_W + 1;
  localparam logic [Y_W-1:0] WY   = Y_W'(WATER_Y);
  localparam logic [Y_W-1:0] RS   = Y_W'(REEL_STEP);
  localparam logic [Y_W-1:0] Y0   = Y_W'(fish_y(2'd0));
  localparam logic [2:0]     ML   = 3'(MAX_LIVES);
  localparam logic [1:0]     LAST = 2'(NUM_LEVELS - 1);

  state_t         state, state_n;
  logic [1:0]     level, level_n;
  logic [Y_W-1:0] ypos, ypos_n;
  logic [2:0]     lives, lives_n;
  logic [7:0]     score, score_n;
  logic [X_W-1:0] fpos;
  logic           clr_pos, clr_tmr, mv_en;
  logic [XW1-1:0] rp, lo, hi;
  logic           hit;

  fish_mover #(
    .X_W       (X_W),
    .SCREEN_W  (SCREEN_W),
    .FISH_TICKS(FISH_TICKS)
  ) u_mover (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr_pos (clr_pos),
    .clr_tmr (clr_tmr),
    .en      (mv_en),
    .dir_left(level[0]),
    .fpos    (fpos)
  );

  // Hit window in one extra bit so fpos+LEN never wraps.
  always_comb begin
    rp  = {1'b0, bus.rpos};
    lo  = {1'b0, fpos};
    hi  = lo + XW1'(fish_len(level));
    hit = (rp >= lo) && (rp <= hi);
  end

  // Next-state and datapath updates; BtnU beats a fish step.
  always_comb begin
    state_n = state;
    level_n = level;
    ypos_n  = ypos;
    lives_n = lives;
    score_n = score;
    clr_pos = 1'b0;
    clr_tmr = 1'b0;
    mv_en   = 1'b0;
    case (state)
      ST_I: begin
        if (bus.Start) begin
          state_n = ST_FISH;
          level_n = 2'd0;
          ypos_n  = Y0;
          lives_n = ML;
          clr_pos = 1'b1;
          clr_tmr = 1'b1;
        end
      end
      ST_FISH: begin
        if (bus.BtnU) begin
          if (hit) begin
            state_n = ST_CATCH;
            clr_tmr = 1'b1;
          end else if (lives > 3'd1) begin
            lives_n = lives - 3'd1;
            clr_pos = 1'b1;
            clr_tmr = 1'b1;
          end else begin
            state_n = ST_I;
            lives_n = 3'd0;
          end
        end else begin
          mv_en = 1'b1;
        end
      end
      ST_CATCH: begin
        if (ypos <= WY) begin
          score_n = (score == 8'hFF) ? score : score + 8'd1;
          if (level == LAST) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_FISH;
            level_n = level + 2'd1;
            ypos_n  = Y_W'(fish_y(level + 2'd1));
            clr_pos = 1'b1;
            clr_tmr = 1'b1;
          end
        end else if (bus.BtnU) begin
          ypos_n = (ypos >= RS) ? ypos - RS : '0;
        end
      end
      ST_DONE: begin
        if (bus.Ack)
          state_n = ST_I;
      end
      default: state_n = ST_I;
    endcase
  end

  // Game registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_I;
      level <= 2'd0;
      ypos  <= Y0;
      lives <= ML;
      score <= 8'd0;
    end else begin
      state <= state_n;
      level <= level_n;
      ypos  <= ypos_n;
      lives <= lives_n;
      score <= score_n;
    end
  end

  assign bus.fpos    = fpos;
  assign bus.ypos    = ypos;
  assign bus.level   = level;
  assign bus.lives   = lives;
  assign bus.score   = score;
  assign bus.q_I     = state[0];
  assign bus.q_Fish  = state[1];
  assign bus.q_Catch = state[2];
  assign bus.q_Done  = state[3];

endmodule

// File: tb/tb_fish_game_ctrl.sv
// Directed bench for fish_game_ctrl.
// Plays a full three-level game plus miss, wrap and reset cases.
module tb_fish_game_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  fish_game_if #(.X_W(10), .Y_W(10)) bus ();

  fish_game_ctrl #(
    .NUM_LEVELS(3),
    .X_W       (10),
    .Y_W       (10),
    .SCREEN_W  (640),
    .FISH_TICKS(4),
    .REEL_STEP (2),
    .WATER_Y   (155),
    .MAX_LIVES (3)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic cy(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    cy(1);
    bus.Start = 1'b0;
  endtask

  initial begin
    Reset     = 1'b0;
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    bus.BtnU  = 1'b0;
    bus.rpos  = '0;
    cy(1);
    chk("rst_qI", bus.q_I, 1);
    chk("rst_fpos", bus.fpos, 0);
    chk("rst_ypos", bus.ypos, 390);
    chk("rst_lives", bus.lives, 3);
    chk("rst_score", bus.score, 0);
    chk("rst_level", bus.level, 0);
    Reset = 1'b1;
    cy(1);
    chk("idle_qI", bus.q_I, 1);

    pulse_start();
    chk("start_qFish", bus.q_Fish, 1);
    chk("start_fpos", bus.fpos, 0);

    cy(12);
    chk("move12_fpos", bus.fpos, 3);
    cy(388);
    chk("move_fpos100", bus.fpos, 100);

    bus.rpos = 10'd121;
    bus.BtnU = 1'b1;
    cy(1);
    bus.BtnU = 1'b0;
    chk("miss_qFish", bus.q_Fish, 1);
    chk("miss_lives", bus.lives, 2);
    chk("miss_fpos", bus.fpos, 0);

    cy(400);
    chk("re_fpos100", bus.fpos, 100);
    bus.rpos = 10'd120;
    bus.BtnU = 1'b1;
    cy(1);
    chk("hit_qCatch", bus.q_Catch, 1);
    chk("hit_fpos", bus.fpos, 100);
    cy(1);
    chk("reel1_ypos", bus.ypos, 388);
    cy(117);
    chk("reel_ypos154", bus.ypos, 154);
    chk("reel_qCatch", bus.q_Catch, 1);
    bus.BtnU = 1'b0;
    cy(1);
    chk("l1_qFish", bus.q_Fish, 1);
    chk("l1_level", bus.level, 1);
    chk("l1_ypos", bus.ypos, 300);
    chk("l1_score", bus.score, 1);
    chk("l1_fpos", bus.fpos, 0);

    cy(4);
    chk("wrap_left", bus.fpos, 639);

    bus.rpos = 10'd639;
    bus.BtnU = 1'b1;
    cy(1);
    chk("l1_hit_qCatch", bus.q_Catch, 1);
    cy(73);
    bus.BtnU = 1'b0;
    chk("l1_reel_ypos", bus.ypos, 154);
    cy(1);
    chk("l2_level", bus.level, 2);
    chk("l2_ypos", bus.ypos, 210);
    chk("l2_score", bus.score, 2);

    cy(2556);
    chk("l2_fpos639", bus.fpos, 639);
    cy(4);
    chk("wrap_right", bus.fpos, 0);

    bus.rpos = 10'd5;
    bus.BtnU = 1'b1;
    cy(1);
    chk("l2_hit_qCatch", bus.q_Catch, 1);
    cy(28);
    bus.BtnU = 1'b0;
    cy(1);
    chk("done_qDone", bus.q_Done, 1);
    chk("done_score", bus.score, 3);
    chk("done_level", bus.level, 2);
    pulse_start();
    chk("done_ign_start", bus.q_Done, 1);
    bus.Ack = 1'b1;
    cy(1);
    bus.Ack = 1'b0;
    chk("ack_qI", bus.q_I, 1);
    chk("ack_score", bus.score, 3);

    pulse_start();
    chk("g2_lives", bus.lives, 3);
    chk("g2_level", bus.level, 0);
    bus.rpos = 10'd100;
    bus.BtnU = 1'b1;
    cy(2);
    chk("g2_lives1", bus.lives, 1);
    chk("g2_qFish", bus.q_Fish, 1);
    cy(1);
    bus.BtnU = 1'b0;
    chk("over_qI", bus.q_I, 1);
    chk("over_lives", bus.lives, 0);

    pulse_start();
    bus.rpos = 10'd0;
    bus.BtnU = 1'b1;
    cy(1);
    chk("g3_qCatch", bus.q_Catch, 1);
    cy(3);
    chk("g3_ypos", bus.ypos, 384);
    #2 Reset = 1'b0;
    #1;
    chk("arst_qI", bus.q_I, 1);
    chk("arst_ypos", bus.ypos, 390);
    chk("arst_lives", bus.lives, 3);
    chk("arst_score", bus.score, 0);
    chk("arst_fpos", bus.fpos, 0);
    bus.BtnU = 1'b0;
    cy(1);
    Reset = 1'b1;
    cy(1);
    chk("post_qI", bus.q_I, 1);
    chk("post_qCatch", bus.q_Catch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
